times_table_loader: RTL and testbench

- AXI4-lite write master that fills the times-table block memory with the products a*b for a, b in 0..7 before the multiplier read stage uses it.
- Sits directly upstream of the multiplier and shares the BRAM's AXI4-lite slave port; write channels only.
- Writes one 32-bit word per table entry, then signals done so read traffic may begin.

---
 rtl/times_table_loader.sv | 163 ++++++++++++++++
 tb/tb_times_table_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/times_table_loader.sv
// AXI4-lite write master that preloads the times-table BRAM with a*b for every
// operand pair, then raises done so the multiplier read stage may start.
module times_table_loader #(
    parameter int unsigned       OP_W      = 3,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [1:0]          dbg_state
);

    localparam int unsigned IDX_W = 2 * OP_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Valid/ready: a channel transfers on a rising edge where valid and ready
    // are both high. Valids here never wait on ready, and awaddr/wdata stay
    // frozen while their valid is high; bready is high only in RESP.

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    function automatic logic [ADDR_W-1:0] entry_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (ADDR_W'(idx) << 2);
    endfunction

    function automatic logic [DATA_W-1:0] entry_data(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] op_a;
        logic [IDX_W-1:0] op_b;
        logic [IDX_W-1:0] prod;
        op_a = IDX_W'(idx[IDX_W-1:OP_W]);
        op_b = IDX_W'(idx[OP_W-1:0]);
        prod = op_a * op_b;
        return DATA_W'(prod);
    endfunction

    logic aw_clear;
    logic w_clear;
    logic [IDX_W-1:0] idx_next;

    // A channel counts as finished if it already handshook or does so this edge.
    assign aw_clear = !awvalid_q || m_axi_awready;
    assign w_clear  = !wvalid_q || m_axi_wready;
    assign idx_next = idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WRITE;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = entry_addr('0);
                    wdata_d   = entry_data('0);
                end
            end
            S_WRITE: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_clear && w_clear)        state_d   = S_RESP;
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    if (&idx_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = S_WRITE;
                        idx_d     = idx_next;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = entry_addr(idx_next);
                        wdata_d   = entry_data(idx_next);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_RESP);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_times_table_loader.sv
// Bench for times_table_loader: an AXI4-lite slave model with random stalls
// captures the table, which is compared with products computed directly.
module tb_times_table_loader;

    localparam int          N_ENT = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  dbg_state;

    times_table_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model state and captured table
    logic [31:0] mem [N_ENT];
    int          wcnt [N_ENT];
    int          aw_total, w_total, b_total;
    int          bp_en     = 0;
    int          err_entry = -1;
    int          aw_cnt, aw_dly, w_cnt, w_dly, b_cnt, b_dly;
    int          aw_got, w_got, b_pending, cur_b_idx;
    logic [31:0] aw_cap, w_cap;
    int          aw_hold, w_hold;
    logic [31:0] aw_hold_addr, w_hold_data;

    function automatic int new_dly(input int max_d);
        return (bp_en != 0) ? int'($urandom_range(0, max_d)) : 0;
    endfunction

    function automatic logic [31:0] ref_product(input int i);
        return 32'((i / 8) * (i % 8));
    endfunction

    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        aw_got = 0; w_got = 0; b_pending = 0; aw_hold = 0; w_hold = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        cur_b_idx = 0; aw_cap = '0; w_cap = '0; aw_hold_addr = '0; w_hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                m_axi_bresp   = 2'b00;
                aw_got = 0; w_got = 0; b_pending = 0; aw_hold = 0; w_hold = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (aw_hold != 0) begin
                    chk("aw_valid_held", 64'(m_axi_awvalid), 64'd1);
                    chk("aw_addr_stable", 64'(m_axi_awaddr), 64'(aw_hold_addr));
                end
                if (w_hold != 0) begin
                    chk("w_valid_held", 64'(m_axi_wvalid), 64'd1);
                    chk("w_data_stable", 64'(m_axi_wdata), 64'(w_hold_data));
                end
                if (m_axi_awvalid) begin
                    m_axi_awready = (aw_cnt >= aw_dly);
                    if (aw_cnt < aw_dly) aw_cnt++;
                end else m_axi_awready = 1'b0;
                if (m_axi_wvalid) begin
                    m_axi_wready = (w_cnt >= w_dly);
                    if (w_cnt < w_dly) w_cnt++;
                end else m_axi_wready = 1'b0;
                if (b_pending != 0) begin
                    m_axi_bvalid = (b_cnt >= b_dly);
                    if (b_cnt < b_dly) b_cnt++;
                end else m_axi_bvalid = 1'b0;
                m_axi_bresp = (m_axi_bvalid && cur_b_idx == err_entry) ? 2'b10 : 2'b00;

                aw_hold      = (m_axi_awvalid && !m_axi_awready) ? 1 : 0;
                aw_hold_addr = m_axi_awaddr;
                w_hold       = (m_axi_wvalid && !m_axi_wready) ? 1 : 0;
                w_hold_data  = m_axi_wdata;

                if (m_axi_awvalid && m_axi_awready) begin
                    aw_got = 1; aw_cap = m_axi_awaddr; aw_cnt = 0; aw_dly = new_dly(3); aw_total++;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_got = 1; w_cap = m_axi_wdata; w_cnt = 0; w_dly = new_dly(1); w_total++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_pending = 0; b_cnt = 0; b_dly = new_dly(2); b_total++;
                end
                if (aw_got != 0 && w_got != 0) begin
                    int e;
                    e = int'((aw_cap - BASE) >> 2);
                    if (e >= 0 && e < N_ENT) begin
                        mem[e] = w_cap;
                        wcnt[e]++;
                    end else chk("aw_range", 64'(aw_cap), 64'(BASE));
                    cur_b_idx = e;
                    b_pending = 1;
                    aw_got = 0;
                    w_got = 0;
                end
            end
        end
    end

    // Driver tasks
    task automatic clear_slave();
        for (int i = 0; i < N_ENT; i++) begin
            mem[i]  = 32'hDEAD_BEEF;
            wcnt[i] = 0;
        end
        aw_total = 0;
        w_total  = 0;
        b_total  = 0;
    endtask

    // Leaves the caller at the falling edge just after start was sampled.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output int busy_fall);
        cyc       = 0;
        busy_fall = -1;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (!busy && busy_fall < 0) busy_fall = cyc;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_entry(input int e, input int max_cyc);
        int n;
        n = 0;
        while (!(m_axi_awvalid && m_axi_awaddr == BASE + 32'(e * 4)) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) chk("entry_timeout", 64'(e), 64'hFFFF);
    endtask

    task automatic check_table(input string tag);
        int bad_data, bad_cnt;
        bad_data = 0;
        bad_cnt  = 0;
        for (int i = 0; i < N_ENT; i++) begin
            if (mem[i] !== ref_product(i)) begin
                bad_data++;
                chk({tag, "_entry"}, 64'(mem[i]), 64'(ref_product(i)));
            end
            if (wcnt[i] != 1) bad_cnt++;
        end
        chk({tag, "_bad_entries"}, 64'(bad_data), 64'd0);
        chk({tag, "_multi_writes"}, 64'(bad_cnt), 64'd0);
        chk({tag, "_aw_count"}, 64'(aw_total), 64'(N_ENT));
        chk({tag, "_w_count"}, 64'(w_total), 64'(N_ENT));
        chk({tag, "_b_count"}, 64'(b_total), 64'(N_ENT));
    endtask

    initial begin
        int cyc, bfall;
        rst   = 1'b0;
        start = 1'b0;
        clear_slave();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_wdata", 64'(m_axi_wdata), 64'd0);
        #2 rst = 1'b1;

        // Full speed
        bp_en = 0;
        clear_slave();
        pulse_start();
        chk("fs_busy", 64'(busy), 64'd1);
        chk("fs_first_addr", 64'(m_axi_awaddr), 64'(BASE));
        chk("fs_first_awvalid", 64'(m_axi_awvalid), 64'd1);
        chk("fs_wstrb", 64'(m_axi_wstrb), 64'hF);
        wait_done(400, cyc, bfall);
        chk("fs_done_latency", 64'(cyc), 64'd129);
        chk("fs_busy_fall", 64'(bfall), 64'd128);
        chk("fs_err", 64'(err), 64'd0);
        check_table("fs");
        chk("fs_entry3f", 64'(mem[63]), 64'd49);
        repeat (4) @(negedge clk);
        chk("fs_done_sticky", 64'(done), 64'd1);

        // Back-pressure with random per-entry stalls
        bp_en = 1;
        clear_slave();
        pulse_start();
        chk("bp_done_cleared", 64'(done), 64'd0);
        wait_done(2000, cyc, bfall);
        chk("bp_err", 64'(err), 64'd0);
        check_table("bp");

        // Error response on entry 20
        err_entry = 20;
        clear_slave();
        pulse_start();
        wait_done(2000, cyc, bfall);
        chk("er_err_set", 64'(err), 64'd1);
        check_table("er");
        err_entry = -1;
        clear_slave();
        pulse_start();
        chk("er_err_cleared", 64'(err), 64'd0);
        wait_done(2000, cyc, bfall);
        chk("er_err_after", 64'(err), 64'd0);
        check_table("er2");

        // Reset mid-load at entry 30
        clear_slave();
        pulse_start();
        wait_entry(30, 2000);
        #2 rst = 1'b0;
        #1;
        chk("mr_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("mr_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_bready", 64'(m_axi_bready), 64'd0);
        chk("mr_awaddr", 64'(m_axi_awaddr), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        clear_slave();
        pulse_start();
        chk("mr_restart_addr", 64'(m_axi_awaddr), 64'(BASE));
        chk("mr_restart_awvalid", 64'(m_axi_awvalid), 64'd1);
        wait_done(2000, cyc, bfall);
        check_table("mr");

        // Start while busy is ignored
        bp_en = 0;
        clear_slave();
        pulse_start();
        wait_entry(5, 400);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_entry(40, 400);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, cyc, bfall);
        chk("sb_err", 64'(err), 64'd0);
        check_table("sb");

        // Multiplier-style reads from the filled table
        chk("rd_6x7", 64'(mem[6 * 8 + 7]), 64'd42);
        chk("rd_0x5", 64'(mem[0 * 8 + 5]), 64'd0);
        chk("rd_7x7", 64'(mem[7 * 8 + 7]), 64'd49);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
